// File: rtl/mem_pkg.sv
// Shared types and width codes for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_LANES = 4;

  // Width comes from funct3[1:0]; halfwords need an even offset, words offset 0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a memory word to the byte offset and sign/zero-extends it per funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rd,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    rd      = '0;
    illegal = 1'b0;
    case (funct3)
      F3_B:    rd = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rd = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rd = shifted;
      F3_BU:   rd = {24'h000000, shifted[7:0]};
      F3_HU:   rd = {16'h0000, shifted[15:0]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with programmable wait states over a
// byte-lane-enabled word array.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  funct3,
  input  logic        WE0,
  input  logic        WE1,
  input  logic        WE2,
  input  logic        WE3,
  output logic        Ready,
  output logic        Done,
  output logic [31:0] RD,
  output logic        Fault
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam int CW    = (WLOAD > 0) ? $clog2(WLOAD + 1) : 1;

  state_t                  state;
  logic [CW-1:0]           cnt;

  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [1:0]              cap_off;
  logic [31:0]             cap_wd;
  logic [2:0]              cap_f3;
  logic                    cap_write;
  logic [BYTE_LANES-1:0]   cap_we;

  logic [ADDR_WIDTH-1:0]   cur_idx;
  logic [1:0]              cur_off;
  logic [31:0]             cur_wd;
  logic [2:0]              cur_f3;
  logic                    cur_write;
  logic [BYTE_LANES-1:0]   cur_we;

  logic [BYTE_LANES-1:0]   cur_mask;
  logic [31:0]             lane_data;
  logic                    cur_fault;
  logic                    enter_resp;

  logic [31:0]             mem [DEPTH];
  logic [31:0]             ext_rd;
  logic                    ext_illegal;

  logic                    unused_addr;
  assign unused_addr = ^A[31:ADDR_WIDTH+2];

  // While IDLE the live inputs describe the request, so a zero-wait access can
  // complete on its own accept edge; afterwards the captured copy is used.
  always_comb begin
    cur_idx   = cap_idx;
    cur_off   = cap_off;
    cur_wd    = cap_wd;
    cur_f3    = cap_f3;
    cur_write = cap_write;
    cur_we    = cap_we;
    if (state == IDLE) begin
      cur_idx   = A[ADDR_WIDTH+1:2];
      cur_off   = A[1:0];
      cur_wd    = WD;
      cur_f3    = funct3;
      cur_write = MemWrite;
      cur_we    = {WE3, WE2, WE1, WE0};
    end
  end

  assign cur_mask  = cur_we << cur_off;
  assign lane_data = cur_wd << {cur_off, 3'b000};

  load_extend u_load_extend (
    .word    (mem[cur_idx]),
    .offset  (cur_off),
    .funct3  (cur_f3),
    .rd      (ext_rd),
    .illegal (ext_illegal)
  );

  always_comb begin
    if (cur_write)
      cur_fault = (cur_we == '0) || cur_f3[2] || misaligned(cur_f3, cur_off);
    else
      cur_fault = ext_illegal || misaligned(cur_f3, cur_off);
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE)
      enter_resp = Req && (WAIT_CYCLES == 0);
    else if (state == WAIT)
      enter_resp = (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      Ready     <= 1'b1;
      Done      <= 1'b0;
      RD        <= '0;
      Fault     <= 1'b0;
      cap_idx   <= '0;
      cap_off   <= '0;
      cap_wd    <= '0;
      cap_f3    <= '0;
      cap_write <= 1'b0;
      cap_we    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            cap_idx   <= A[ADDR_WIDTH+1:2];
            cap_off   <= A[1:0];
            cap_wd    <= WD;
            cap_f3    <= funct3;
            cap_write <= MemWrite;
            cap_we    <= {WE3, WE2, WE1, WE0};
            Ready     <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CW'(WLOAD);
            end
          end
        end
        WAIT: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
        end
        RESP: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
      endcase
      // Stores and faults leave RD cleared; only a clean load returns data.
      if (enter_resp) begin
        state <= RESP;
        Done  <= 1'b1;
        Fault <= cur_fault;
        RD    <= (cur_write || cur_fault) ? '0 : ext_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_write && !cur_fault) begin
      for (int k = 0; k < BYTE_LANES; k++) begin
        if (cur_mask[k])
          mem[cur_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

endmodule
